// File: rtl/lsu_pkg.sv
// Shared encodings and types for the LSU word-memory port.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;

  // Request as captured at acceptance; addr is already masked to 4 KiB.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [11:0] addr;
    logic        err;
  } lsu_req_t;

endpackage

// File: rtl/lsu_lane_fmt.sv
// Little-endian lane extraction/extension for loads and byte/half merge for stores.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = mem_word_i[{off_i, 3'b000} +: 8];
    half_sel  = off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    ld_data_o = mem_word_i;
    st_word_o = mem_word_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
        st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ld_data_o = {{16{sgn_i & half_sel[15]}}, half_sel};
        if (off_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else          st_word_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        ld_data_o = mem_word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU port onto a 1K x 32 synchronous-read word memory; sub-word stores do read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned/reserved-size requests instead of masking them.
module lsu_mem_port
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  state_e      state_q, state_d;
  lsu_req_t    op_q;
  logic [31:0] wr_word_q, rdata_q;
  logic [1:0]  size_n;
  logic        err_n;
  logic [11:0] addr_n;
  logic        accept;
  logic [31:0] ld_data, st_word;

  // Upper address bits alias within the 4 KiB window.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:12];

  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    size_n = req_size;
    err_n  = ((req_size == SZ_HALF) && req_addr[0]) ||
             ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
             (req_size == SZ_RSVD);
`else
    size_n = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    err_n  = 1'b0;
`endif
    addr_n = req_addr[11:0];
    if (size_n == SZ_HALF)      addr_n[0]   = 1'b0;
    else if (size_n != SZ_BYTE) addr_n[1:0] = 2'b00;
  end

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (err_n)                              state_d = RESP;
        else if (req_we && (size_n == SZ_WORD)) state_d = WR;
        else                                    state_d = RD;
      end
      RD:      state_d = CAP;
      CAP:     state_d = op_q.we ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= '{we: req_we, size: size_n, sgn: req_signed, addr: addr_n, err: err_n};
        wr_word_q <= req_wdata;
      end
      // mem_dout holds the word addressed during RD.
      if (state_q == CAP) begin
        if (op_q.we) wr_word_q <= st_word;
        else         rdata_q   <= ld_data;
      end
    end
  end

  lsu_lane_fmt u_fmt (
    .size_i     (op_q.size),
    .sgn_i      (op_q.sgn),
    .off_i      (op_q.addr[1:0]),
    .mem_word_i (mem_dout),
    .wdata_i    (wr_word_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && op_q.err;
  assign resp_rdata = rdata_q;
  assign mem_we     = (state_q == WR);
  assign mem_din    = (state_q == WR) ? wr_word_q : '0;
  assign mem_addr   = ((state_q == RD) || (state_q == WR)) ? op_q.addr[11:2] : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed requests push expectations, a monitor checks responses.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we;

  lsu_mem_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          exp_wr = 0;
  int          wr_total = 0;
  int          wr_snap;
  logic        preload;
  logic [9:0]  last_wa = '0;
  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h8070_6050;
      mem[1] <= 32'h1122_3344;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
      wr_total      <= wr_total + 1;
      last_wa       <= mem_addr;
    end
    mem_dout <= mem[mem_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
        chk("latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
        chk("write_count", 32'(wr_total), 32'(mon_e.wr));
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat);
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    if (we && !eerr) exp_wr++;
    e.rdata = erd; e.err = eerr; e.lat = elat; e.wr = exp_wr;
    exp_q.push_back(e);
    acc_cyc = cyc;
    @(negedge clk);
    // Scramble the request fields: the DUT must have latched them already.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
    req_addr = ~addr; req_wdata = ~wd;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    preload = 1'b0;
    rst = 1'b0;

    // Loads from word 0 = 0x8070_6050
    issue(0, 2'b00, 1, 32'h0000_0003, 0, 32'hFFFF_FF80, 0, 3);
    issue(0, 2'b01, 0, 32'h0000_0002, 0, 32'h0000_8070, 0, 3);
    issue(0, 2'b00, 0, 32'hFFFF_F001, 0, 32'h0000_0060, 0, 3);
    issue(0, 2'b01, 1, 32'h0000_0000, 0, 32'h0000_6050, 0, 3);
    issue(0, 2'b01, 1, 32'h0000_0002, 0, 32'hFFFF_8070, 0, 3);
    issue(0, 2'b10, 0, 32'h0000_0000, 0, 32'h8070_6050, 0, 3);

    // Stores into word 1 = 0x1122_3344; resp_rdata holds the last load
    issue(1, 2'b00, 0, 32'h0000_0005, 32'hFFFF_FFAB, 32'h8070_6050, 0, 4);
    chk("mem1_after_sb", mem[1], 32'h1122_AB44);
    issue(1, 2'b01, 0, 32'h0000_0006, 32'h1234_BEEF, 32'h8070_6050, 0, 4);
    chk("mem1_after_sh", mem[1], 32'hBEEF_AB44);
    issue(1, 2'b10, 0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h8070_6050, 0, 2);
    chk("mem1_after_sw", mem[1], 32'hDEAD_BEEF);
    chk("sw_mem_addr", {22'b0, last_wa}, 32'h0000_0001);

`ifdef LSU_ALIGN_CHECK_EN
    issue(0, 2'b10, 0, 32'h0000_0002, 0, 32'h8070_6050, 1, 1);
    issue(1, 2'b10, 0, 32'h0000_0005, 32'h1234_5678, 32'h8070_6050, 1, 1);
    issue(0, 2'b11, 0, 32'h0000_0004, 0, 32'h8070_6050, 1, 1);
    issue(0, 2'b01, 1, 32'h0000_0001, 0, 32'h8070_6050, 1, 1);
`else
    issue(0, 2'b10, 0, 32'h0000_0002, 0, 32'h8070_6050, 0, 3);
    issue(1, 2'b10, 0, 32'h0000_0007, 32'hDEAD_BEEF, 32'h8070_6050, 0, 2);
    issue(0, 2'b11, 0, 32'h0000_0004, 0, 32'hDEAD_BEEF, 0, 3);
    issue(0, 2'b01, 1, 32'h0000_0001, 0, 32'h0000_6050, 0, 3);
`endif
    chk("mem1_after_misc", mem[1], 32'hDEAD_BEEF);

    // Reset while a half store sits in CAP: no write, no response
    wr_snap = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h0000_0006; req_wdata = 32'h0000_5555;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_resp_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", 32'(wr_total), 32'(wr_snap));
    chk("midrst_mem1", mem[1], 32'hDEAD_BEEF);

    issue(0, 2'b00, 0, 32'h0000_0004, 0, 32'h0000_00EF, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The module SHALL have ports `clk` (input, 1): the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port `rst` (input, 1): asynchronous, active-high reset.
REQ-003 The module SHALL have ports `req_valid` (input, 1) and `req_ready` (output, 1): CPU-side request handshake.
REQ-004 The module SHALL have port `req_we` (input, 1): 1 = store, 0 = load.
REQ-005 The module SHALL have port `req_size` (input, 2): 00 byte, 01 half, 10 word, 11 reserved.
REQ-006 The module SHALL have port `req_signed` (input, 1): sign-extend sub-word load data.
REQ-007 The module SHALL have ports `req_addr` (input, 32): byte address, and `req_wdata` (input, 32): store data, right-aligned.
REQ-008 The module SHALL have ports `resp_valid` (output, 1): one-cycle completion pulse, and `resp_rdata` (output, 32): load result.
REQ-009 The module SHALL have port `resp_err` (output, 1): misaligned or reserved-size request; qualified by `resp_valid`.
REQ-010 The module SHALL have ports `mem_addr` (output, 10), `mem_din` (output, 32) and `mem_we` (output, 1): word-memory address, write data and write enable.
REQ-011 The module SHALL have port `mem_dout` (input, 32): word-memory read data, valid the cycle after a read address is presented with `mem_we`=0.

Function
REQ-012 The request SHALL be accepted on a rising edge where `req_valid` and `req_ready` are both 1; `req_ready` SHALL equal 1 only in IDLE.
REQ-013 All `req_*` fields SHALL be latched at acceptance; later changes SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, RD, CAP, WR and RESP.
REQ-015 From IDLE, transitions SHALL be: error -> RESP; word store -> WR; all others -> RD.
REQ-016 RD SHALL drive `mem_addr` = addr[11:2] with `mem_we`=0, then go to CAP.
REQ-017 In CAP, a load SHALL register the extracted and extended data into `resp_rdata` -> RESP.
REQ-018 In CAP, a sub-word store SHALL register the merged word (`mem_dout` with the addressed byte or half replaced) -> WR.
REQ-019 WR SHALL drive `mem_we`=1, `mem_addr` and `mem_din` for exactly one cycle -> RESP.
REQ-020 RESP SHALL assert `resp_valid` for exactly one cycle -> IDLE.
REQ-021 Byte lanes SHALL be little-endian: offset 0 = bits 7:0; a half at offset 2 = bits 31:16.
REQ-022 Unsigned loads SHALL zero-extend; signed loads SHALL replicate the top bit of the loaded byte or half.
REQ-023 Latency from the accept edge to `resp_valid` SHALL be: load 3 cycles; word store 2 cycles; sub-word store 4 cycles; error 1 cycle.
REQ-024 Address bits [31:12] SHALL be ignored (wrap-around within 4 KiB).
REQ-025 `mem_we` SHALL be 0 in every state except WR.
REQ-026 `resp_rdata` SHALL hold its value until the next load completes.
REQ-027 On an error response, no memory access SHALL occur and `resp_rdata` SHALL be unchanged.

Reset
REQ-028 `rst`=1 SHALL immediately force IDLE with `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_addr`=0 and `mem_din`=0.
REQ-029 A reset mid-operation SHALL abandon the request with no response; a write not yet in WR SHALL never be issued.
REQ-030 After reset deassertion, `req_ready`=1 from the first clock.

Configuration
REQ-031 With `LSU_ALIGN_CHECK_EN` defined, `resp_err` SHALL be set for: a half access with addr[0]=1; a word access with addr[1:0]≠0; or `req_size`=11.
REQ-032 Without `LSU_ALIGN_CHECK_EN`, `resp_err` SHALL be tied to 0, low address bits SHALL be masked to natural alignment, and size 11 SHALL behave as word.

Structure
REQ-033 Package `lsu_pkg` SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-034 Lane extraction/extension and store merge SHALL live in one combinational sub-module, `lsu_lane_fmt`.

Verification
REQ-035 Load byte, signed: memory word 0 = 0x8070_6050, lb addr 0x003 -> `resp_rdata` 0xFFFF_FF80, `resp_valid` 3 cycles after accept.
REQ-036 Load half, unsigned: same memory word, lhu addr 0x002 -> `resp_rdata` 0x0000_8070.
REQ-037 Store byte: memory word 1 = 0x1122_3344, sb addr 0x005 data 0xAB -> one `mem_we` pulse writing 0x1122_AB44; `resp_valid` 4 cycles after accept.
REQ-038 Store word: sw addr 0x1004 data 0xDEAD_BEEF -> `mem_addr` 0x001, single write, `resp_valid` 2 cycles after accept.
REQ-039 Misaligned access with the macro defined: lw addr 0x002 -> `resp_err`=1 after 1 cycle, no memory access.
REQ-040 Reset mid-operation: assert `rst` during CAP of an sh -> no write and no `resp_valid`; `req_ready`=1 after release.
